bcd_7seg_scan_driver: RTL

- Multiplexed multi-digit BCD-to-7-segment display driver.
- Holds a packed BCD word and time-multiplexes one shared segment bus across `NUM_DIGITS` digit anodes.
- Inserts a one-cycle blank between digits to suppress ghosting; new data is accepted through a valid/ready handshake and applied only at frame boundaries, so a displayed frame never tears.
- Sits between datapath or counter logic producing BCD and the board's display pins.

---
 rtl/bcd_7seg_scan_driver_pkg.sv | 27 ++
 rtl/bcd_7seg_scan_driver_bcd_to_seg7.sv | 26 ++
 rtl/bcd_7seg_scan_driver.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bcd_7seg_scan_driver_pkg.sv
// Shared definitions for the multiplexed BCD 7-segment driver: segment
// patterns ({a,b,c,d,e,f,g}, active-high), scan FSM states and a width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    typedef enum logic {
        DRIVE = 1'b0,
        BLANK = 1'b1
    } state_t;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_7seg_scan_driver_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high {a,b,c,d,e,f,g}.
// Codes 10..15 produce all segments off.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Multiplexed multi-digit BCD 7-segment scan driver with frame-aligned loads.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module bcd_7seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int IDX_W = cnt_width(NUM_DIGITS);
    localparam int DIV_W = cnt_width(REFRESH_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [DIV_W-1:0]        div;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_valid;
    logic                    blank_q;

    logic                    digit_end;
    logic                    frame_end;
    logic                    accept;
    logic [3:0]              digit_code;
    logic [6:0]              digit_seg;
    logic [NUM_DIGITS-1:0]   suppress;
    logic                    cur_suppressed;
    logic                    drive_on;
    logic [NUM_DIGITS-1:0]   an_on;
    logic [6:0]              seg_on;

    assign digit_end  = (state == DRIVE) && (div == DIV_LAST);
    assign frame_end  = digit_end && (idx == IDX_LAST);
    assign load_ready = !pending_valid;
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BLANK;
            idx           <= '0;
            div           <= '0;
            active        <= '0;
            pending_valid <= 1'b0;
            blank_q       <= 1'b0;
        end else begin
            // blank is registered so no input reaches an output combinationally
            blank_q <= blank;
            case (state)
                DRIVE: begin
                    if (div == DIV_LAST) begin
                        state <= BLANK;
                        div   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                BLANK: state <= DRIVE;
                default: state <= BLANK;
            endcase
            // accept and promote are exclusive: accept needs pending_valid low
            if (accept) begin
                pending_valid <= 1'b1;
            end
            if (frame_end && pending_valid) begin
                active        <= pending;
                pending_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pending <= load_data;
        end
    end

    always_comb begin
        digit_code = active[3:0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                digit_code = active[i*4 +: 4];
            end
        end
    end

    bcd_to_seg7 u_dec (
        .code (digit_code),
        .seg  (digit_seg)
    );

`ifdef SEG7_LZB_EN
    logic higher_zero;

    // A digit is suppressed when it and every digit above it are zero.
    always_comb begin
        suppress    = '0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            higher_zero = higher_zero && (active[i*4 +: 4] == 4'd0);
            suppress[i] = higher_zero;
        end
    end
`else
    assign suppress = '0;
`endif

    always_comb begin
        cur_suppressed = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_suppressed = suppress[i];
            end
        end
    end

    assign drive_on = (state == DRIVE) && !cur_suppressed;

    always_comb begin
        an_on = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_on[i] = drive_on && !blank_q && (idx == IDX_W'(i));
        end
    end

    assign seg_on     = drive_on ? digit_seg : SEG_OFF;
    assign an         = (AN_ACTIVE_LOW != 0) ? ~an_on : an_on;
    assign seg        = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
    assign frame_tick = frame_end;

endmodule
